// File: rtl/rv_pkg.sv
// Shared RISC-V definitions: opcode and load funct3 constants, plus the
// write-back buffer entry layout.
package rv_pkg;

    localparam int WB_DEPTH = 2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] mem_data;
    } wb_entry_t;

    function automatic logic load_f3_valid(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Formats an aligned 32-bit memory word into load data by funct3 and byte
// offset, and flags halfword/word accesses that are not naturally aligned.
module wb_load_align
    import rv_pkg::*;
(
    input  logic [31:0] mem_data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_data[7:0];
        case (offset)
            2'd0: byte_sel = mem_data[7:0];
            2'd1: byte_sel = mem_data[15:8];
            2'd2: byte_sel = mem_data[23:16];
            2'd3: byte_sel = mem_data[31:24];
            default: byte_sel = mem_data[7:0];
        endcase
        half_sel = offset[1] ? mem_data[31:16] : mem_data[15:0];
    end

    // Undefined funct3 yields zero data and no misalign; the caller drops it.
    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'h0, byte_sel};
            F3_LH: begin
                if (offset[0]) misalign = 1'b1;
                else           data = {{16{half_sel[15]}}, half_sel};
            end
            F3_LHU: begin
                if (offset[0]) misalign = 1'b1;
                else           data = {16'h0, half_sel};
            end
            F3_LW: begin
                if (offset != 2'd0) misalign = 1'b1;
                else                data = mem_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: 2-entry input buffer, architectural result select,
// registered register-file write port and a 64-bit retired-instruction counter.
module write_back
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IR,
    input  logic [31:0] PC,
    input  logic [31:0] result,
    input  logic [31:0] mem_data,
    input  logic        v_in,
    output logic        r_out,
    input  logic        stall,
    output logic [4:0]  WB_address,
    output logic [31:0] WB_data,
    output logic        v_wb,
    output logic        misalign,
    output logic [63:0] retire_count
);

    wb_entry_t   buf_q [WB_DEPTH];
    wb_entry_t   head;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] load_data;
    logic        load_misalign;
    logic        nxt_wr;
    logic [31:0] nxt_data;
    logic        nxt_mis;
    logic        unused_ir_bits;

    assign r_out = (count != 2'(WB_DEPTH));
    assign push  = v_in & r_out;
    assign pop   = (count != 2'd0) & ~stall;
    assign head  = buf_q[rd_ptr];

    assign opc = head.ir[6:0];
    assign rd  = head.ir[11:7];
    assign f3  = head.ir[14:12];
    assign unused_ir_bits = ^head.ir[31:15];

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr] <= '{ir: IR, pc: PC, result: result, mem_data: mem_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    wb_load_align u_load_align (
        .mem_data (head.mem_data),
        .funct3   (f3),
        .offset   (head.result[1:0]),
        .data     (load_data),
        .misalign (load_misalign)
    );

    always_comb begin
        nxt_wr   = 1'b0;
        nxt_data = '0;
        nxt_mis  = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: begin
                nxt_wr   = 1'b1;
                nxt_data = head.result;
            end
            OPC_JAL, OPC_JALR: begin
                nxt_wr   = 1'b1;
                nxt_data = head.pc + 32'd4;
            end
            OPC_LOAD: begin
                if (load_f3_valid(f3)) begin
                    if (load_misalign) begin
                        nxt_mis = 1'b1;
                    end else begin
                        nxt_wr   = 1'b1;
                        nxt_data = load_data;
                    end
                end
            end
            default: ;
        endcase
        if (rd == 5'd0) nxt_wr = 1'b0;
    end

    // Idle or stalled cycles present a zero write so the read stage hits x0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_wb         <= 1'b0;
            WB_address   <= '0;
            WB_data      <= '0;
            misalign     <= 1'b0;
            retire_count <= '0;
        end else if (pop) begin
            v_wb         <= nxt_wr;
            WB_address   <= nxt_wr ? rd : 5'd0;
            WB_data      <= nxt_wr ? nxt_data : 32'd0;
            misalign     <= nxt_mis;
            retire_count <= retire_count + 64'd1;
        end else begin
            v_wb       <= 1'b0;
            WB_address <= '0;
            WB_data    <= '0;
            misalign   <= 1'b0;
        end
    end

endmodule

// File: doc/write_back.md
# write_back

Final pipeline stage of the flat RISC-V core. It accepts completed instructions from the memory stage through a 2-entry buffer and selects the architectural result: ALU result, formatted load data, or the link address. It drives the register-file write port (WB_address, WB_data, v_wb) that the read stage samples and forwards from. It also keeps a 64-bit retired-instruction counter.

## Interface
- DEPTH, 2, buffer entries; fixed at 2, other values unsupported.
- clk  in  1  pipeline clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IR  in  32  instruction word of incoming entry.
- PC  in  32  PC of incoming entry.
- result  in  32  ALU result; effective address for loads.
- mem_data  in  32  aligned 32-bit word read by the memory stage.
- v_in  in  1  upstream entry valid.
- r_out  out  1  ready to upstream; transfer when v_in & r_out at a rising edge.
- stall  in  1  hazard hold; no entry retires while high.
- WB_address  out  5  destination register; 0 whenever v_wb=0.
- WB_data  out  32  write data; 0 whenever v_wb=0.
- v_wb  out  1  register write valid this cycle.
- misalign  out  1  one-cycle pulse, aligned with the outputs of a misaligned load.
- retire_count  out  64  instructions retired since reset.

## Operation
- Buffer: 2-entry FIFO of {IR, PC, result, mem_data}. r_out = (count != 2), combinational from count.
- Pop: one entry per edge when count != 0 and stall=0. Push and pop on the same edge leaves count unchanged.
- Destination: rd = IR[11:7]. No write (v_wb=0, WB_address=0, WB_data=0) when rd == 0.
- Result select by IR[6:0], for a popped entry:
  - LUI, AUIPC, OP (0110011), OP-IMM (0010011): WB_data = result.
  - JAL, JALR: WB_data = PC + 32'd4, mod 2^32.
  - LOAD (0000011): formatted mem_data, selected by funct3 = IR[14:12] and offset = result[1:0].
    - LB: sign-extended byte at offset. LBU: zero-extended byte at offset.
    - LH: sign-extended half at result[1]. LHU: zero-extended half at result[1].
    - LW: full word.
  - BRANCH, STORE, any other opcode: no write; still retires.
- Misaligned load: LH/LHU with result[0]=1, or LW with result[1:0] != 0.
  - No write; misalign=1 for that output cycle; still retires.
  - LOAD with an undefined funct3: no write, no misalign.
- retire_count: +1 per popped entry, regardless of write or misalign. Wraps at 2^64.

## Timing
- Outputs are registered. An entry popped at edge k drives WB_* / v_wb / misalign during cycle k..k+1. The read stage writes it at edge k+1.
- Latency: entry accepted at edge a, with FIFO empty and stall low, pops at edge a+1.
- Cycles with no pop (empty FIFO or stall=1) register v_wb=0, WB_address=0, WB_data=0, misalign=0. The read stage's unconditional write then targets x0 harmlessly.
- Full FIFO: r_out=0; upstream holds its entry. Accept resumes on the cycle after the first pop.
- stall asserted mid-stream: the head is held, not dropped. Order is preserved across stall.
- Reset (asynchronous, any time), all cleared immediately:
  - count=0, so r_out=1.
  - v_wb=0, WB_address=0, WB_data=0, misalign=0, retire_count=0.
  - Buffer contents discarded, including any entry mid-transfer.

## Structure
- Shared package rv_pkg: opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP), load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU), and the buffer entry struct. The same opcode constants serve the read stage's immediate decoder.
- One sub-module, wb_load_align: combinational; inputs mem_data, funct3, offset; outputs formatted data and misalign. Remainder (FIFO, select, counter, output registers) lives in write_back.

## Test plan
- ADDI rd=5, result=32'h0000_0007, single entry, stall=0 -> one cycle v_wb=1, WB_address=5, WB_data=7; retire_count=1.
- LB rd=3, mem_data=32'h80FF_7F01, offsets 0..3 -> WB_data 0000_0001, 0000_007F, FFFF_FFFF, FFFF_FF80. LBU at offset 3 -> 0000_0080.
- LW rd=4, result=32'h1002 -> v_wb=0, WB_address=0, misalign=1 for one cycle, retire_count +1.
- JAL rd=1, PC=32'hFFFF_FFFC -> WB_data=0. JAL rd=0 -> v_wb=0.
- Back-to-back stream with stall=1 for 3 cycles:
  - r_out falls after 2 accepts; v_wb stays 0 throughout the stall.
  - After release, entries retire in order, one per cycle; no loss or duplication.
- Assert rst_n=0 mid-drain with count=2 -> outputs and retire_count 0 immediately, r_out=1; no stale write after release.
